// File: rtl/mc_datapath_if.sv
// rtl/mc_datapath_if.sv - control-strobe, instruction-ROM and decode/result bundle for mc_datapath
interface mc_datapath_if;
  logic        PC_Write;
  logic        IR_Write;
  logic        Reg_Write;
  logic        rs2_imm_s;
  logic        w_data_s;
  logic [3:0]  ALU_OP;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] alu_f;
  logic        zf;
  logic        sf;
  logic        cf;
  logic        of;

  modport master (
    output PC_Write, IR_Write, Reg_Write, rs2_imm_s, w_data_s, ALU_OP, inst_rdata,
    input  inst_addr, opcode, funct3, funct7, alu_f, zf, sf, cf, of
  );

  modport slave (
    input  PC_Write, IR_Write, Reg_Write, rs2_imm_s, w_data_s, ALU_OP, inst_rdata,
    output inst_addr, opcode, funct3, funct7, alu_f, zf, sf, cf, of
  );
endinterface

// File: rtl/mc_datapath.sv
// rtl/mc_datapath.sv - multi-cycle RV32I datapath: PC, IR, register file, A/B latches, ALU, F and flags
// Define MC_DATAPATH_DEBUG_EN to add a combinational register-file read port (dbg_raddr/dbg_rdata).
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef MC_DATAPATH_DEBUG_EN
  input  logic [4:0]   dbg_raddr,
  output logic [31:0]  dbg_rdata,
`endif
  mc_datapath_if.slave bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, b_q;
  logic [31:0] f_q;
  logic        zf_q, sf_q, cf_q, of_q;
  logic [31:0] rf_q [32];

  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_u;
  logic [31:0] op2;
  logic [31:0] wb_data;
  logic [32:0] sum, dif;
  logic [4:0]  shamt;
  logic [31:0] alu_r;
  logic        alu_c, alu_v, alu_ok;
  logic        zf_d, sf_d;

  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign rd      = ir_q[11:7];
  assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_u   = {ir_q[31:12], 12'b0};
  assign op2     = bus.rs2_imm_s ? imm_i : b_q;
  assign wb_data = bus.w_data_s ? imm_u : f_q;
  assign pc_d    = bus.PC_Write ? pc_q + 32'(PC_STEP) : pc_q;
  assign ir_d    = bus.IR_Write ? bus.inst_rdata : ir_q;

  assign sum   = {1'b0, a_q} + {1'b0, op2};
  assign dif   = {1'b0, a_q} - {1'b0, op2};
  assign shamt = op2[4:0];

  // Undefined ALU codes report zero with every flag clear, including zf.
  always_comb begin
    alu_r  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    alu_ok = 1'b1;
    case (bus.ALU_OP)
      4'b0000: begin
        alu_r = sum[31:0];
        alu_c = sum[32];
        alu_v = (a_q[31] == op2[31]) && (sum[31] != a_q[31]);
      end
      4'b1000: begin
        alu_r = dif[31:0];
        alu_c = dif[32];
        alu_v = (a_q[31] != op2[31]) && (dif[31] != a_q[31]);
      end
      4'b0001: alu_r = a_q << shamt;
      4'b0010: alu_r = {31'b0, $signed(a_q) < $signed(op2)};
      4'b0011: alu_r = {31'b0, a_q < op2};
      4'b0100: alu_r = a_q ^ op2;
      4'b0101: alu_r = a_q >> shamt;
      4'b1101: alu_r = 32'($signed(a_q) >>> shamt);
      4'b0110: alu_r = a_q | op2;
      4'b0111: alu_r = a_q & op2;
      default: alu_ok = 1'b0;
    endcase
  end

  assign zf_d = alu_ok && (alu_r == 32'd0);
  assign sf_d = alu_r[31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      f_q  <= '0;
      zf_q <= 1'b0;
      sf_q <= 1'b0;
      cf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q  <= rf_q[rs1];
      b_q  <= rf_q[rs2];
      f_q  <= alu_r;
      zf_q <= zf_d;
      sf_q <= sf_d;
      cf_q <= alu_c;
      of_q <= alu_v;
    end
  end

  // x0 is never written, so its reset value keeps every read of it at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (bus.Reg_Write && (rd != 5'd0)) begin
      rf_q[rd] <= wb_data;
    end
  end

  assign bus.inst_addr = pc_q;
  assign bus.opcode    = ir_q[6:0];
  assign bus.funct3    = ir_q[14:12];
  assign bus.funct7    = ir_q[31:25];
  assign bus.alu_f     = f_q;
  assign bus.zf        = zf_q;
  assign bus.sf        = sf_q;
  assign bus.cf        = cf_q;
  assign bus.of        = of_q;

`ifdef MC_DATAPATH_DEBUG_EN
  assign dbg_rdata = rf_q[dbg_raddr];
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// tb/tb_mc_datapath.sv - self-checking bench for mc_datapath against a behavioural reference model
module tb_mc_datapath;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc_datapath_if bus ();
  mc_datapath_if bus2 ();

  logic [31:0] rom [1024];
  assign bus.inst_rdata  = rom[bus.inst_addr[11:2]];
  assign bus2.inst_rdata = rom[bus2.inst_addr[11:2]];

`ifdef MC_DATAPATH_DEBUG_EN
  logic [4:0]  dbg_raddr, dbg_raddr2;
  logic [31:0] dbg_rdata, dbg_rdata2;
  mc_datapath #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .bus(bus));
  mc_datapath #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .dbg_raddr(dbg_raddr2), .dbg_rdata(dbg_rdata2), .bus(bus2));
`else
  mc_datapath #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  mc_datapath #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus2));
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc, m_ir, m_a, m_b, m_f;
  logic        m_zf, m_sf, m_cf, m_of;
  logic [31:0] m_x [32];

  task automatic model_reset();
    m_pc = 32'h0; m_ir = 32'h0; m_a = 32'h0; m_b = 32'h0; m_f = 32'h0;
    m_zf = 1'b0; m_sf = 1'b0; m_cf = 1'b0; m_of = 1'b0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
  endtask

  // Arithmetic reference: carries and overflow judged on wide integers.
  task automatic alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z, output logic s,
                         output logic c, output logic o);
    longint sa, sb, t;
    bit ok;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t = 0; ok = 1'b1; r = 32'h0; c = 1'b0; o = 1'b0;
    case (op)
      4'd0: begin
        r = a + b;
        c = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
        t = sa + sb;
        o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd8: begin
        r = a - b;
        c = a < b;
        t = sa - sb;
        o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd1:  r = a << b[4:0];
      4'd2:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  r = (a < b) ? 32'd1 : 32'd0;
      4'd4:  r = a ^ b;
      4'd5:  r = a >> b[4:0];
      4'd13: begin t = sa >>> b[4:0]; r = t[31:0]; end
      4'd6:  r = a | b;
      4'd7:  r = a & b;
      default: ok = 1'b0;
    endcase
    z = ok && (r == 32'h0);
    s = r[31];
  endtask

  task automatic cycle(input bit pw, input bit iw, input bit rw, input bit imm_s,
                       input bit wd_s, input logic [3:0] op);
    logic [31:0] r, na, nb, immi;
    logic z, s, c, o;
    bus.PC_Write = pw; bus.IR_Write = iw; bus.Reg_Write = rw;
    bus.rs2_imm_s = imm_s; bus.w_data_s = wd_s; bus.ALU_OP = op;
    @(posedge clk);
    immi = {{20{m_ir[31]}}, m_ir[31:20]};
    alu_ref(op, m_a, imm_s ? immi : m_b, r, z, s, c, o);
    na = m_x[m_ir[19:15]];
    nb = m_x[m_ir[24:20]];
    if (rw && m_ir[11:7] != 5'd0) m_x[m_ir[11:7]] = wd_s ? {m_ir[31:12], 12'h000} : m_f;
    if (iw) m_ir = rom[m_pc[11:2]];
    if (pw) m_pc = m_pc + 32'd4;
    m_a = na; m_b = nb; m_f = r;
    m_zf = z; m_sf = s; m_cf = c; m_of = o;
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [31:0] ins, input bit imm_s, input logic [3:0] op,
                           input bit rw, input bit wd_s);
    rom[m_pc[11:2]] = ins;
    cycle(1, 1, 0, imm_s, wd_s, op);
    cycle(0, 0, 0, imm_s, wd_s, op);
    cycle(0, 0, 0, imm_s, wd_s, op);
    cycle(0, 0, rw, imm_s, wd_s, op);
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic read_reg(input int idx, output logic [31:0] v);
    run_instr(enc_i(12'h000, 5'(idx), 3'b000, 5'd0), 1, 4'd0, 0, 0);
    v = bus.alu_f;
  endtask

  task automatic test_reset();
    bus.PC_Write = 0; bus.IR_Write = 0; bus.Reg_Write = 0;
    bus.rs2_imm_s = 0; bus.w_data_s = 0; bus.ALU_OP = 4'd0;
    bus2.PC_Write = 0; bus2.IR_Write = 0; bus2.Reg_Write = 0;
    bus2.rs2_imm_s = 0; bus2.w_data_s = 0; bus2.ALU_OP = 4'd0;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.inst_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.inst_addr, 32'h0); end
    checks++; if (bus.opcode !== 7'h0) begin errors++; $display("FAIL reset_opcode: got %h expected %h", bus.opcode, 7'h0); end
    checks++; if (bus.alu_f !== 32'h0) begin errors++; $display("FAIL reset_f: got %h expected %h", bus.alu_f, 32'h0); end
    checks++; if ({bus.zf, bus.sf, bus.cf, bus.of} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.zf, bus.sf, bus.cf, bus.of}); end
    checks++; if (bus2.inst_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc_param: got %h expected %h", bus2.inst_addr, 32'hFFFF_FFFC); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pc_wrap();
    logic [31:0] w;
    w = rom[1023];
    bus2.PC_Write = 1; bus2.IR_Write = 1;
    cycle(0, 0, 0, 0, 0, 4'd0);
    bus2.PC_Write = 0; bus2.IR_Write = 0;
    checks++; if (bus2.inst_addr !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h expected %h", bus2.inst_addr, 32'h0); end
    checks++; if (bus2.opcode !== w[6:0]) begin errors++; $display("FAIL pc_wrap_ir: got %h expected %h", bus2.opcode, w[6:0]); end
  endtask

  task automatic test_fetch();
    logic [31:0] ins;
    ins = $urandom();
    rom[m_pc[11:2]] = ins;
    cycle(1, 1, 0, 0, 0, 4'd0);
    checks++; if ({bus.funct7, bus.funct3, bus.opcode} !== {ins[31:25], ins[14:12], ins[6:0]}) begin errors++; $display("FAIL fetch_decode: got %h expected %h", {bus.funct7, bus.funct3, bus.opcode}, {ins[31:25], ins[14:12], ins[6:0]}); end
    checks++; if (bus.inst_addr !== m_pc) begin errors++; $display("FAIL fetch_pc: got %h expected %h", bus.inst_addr, m_pc); end
    cycle(0, 1, 0, 0, 0, 4'd0);
    checks++; if (bus.inst_addr !== m_pc) begin errors++; $display("FAIL ir_only_pc_hold: got %h expected %h", bus.inst_addr, m_pc); end
  endtask

  task automatic test_addi();
    logic [31:0] v;
    run_instr(32'hFFB0_0093, 1, 4'd0, 1, 0);
    checks++; if (bus.alu_f !== 32'hFFFF_FFFB) begin errors++; $display("FAIL addi_f: got %h expected %h", bus.alu_f, 32'hFFFF_FFFB); end
    checks++; if ({bus.sf, bus.zf} !== 2'b10) begin errors++; $display("FAIL addi_flags: got %b expected 10", {bus.sf, bus.zf}); end
    read_reg(1, v);
    checks++; if (v !== 32'hFFFF_FFFB) begin errors++; $display("FAIL addi_x1: got %h expected %h", v, 32'hFFFF_FFFB); end
  endtask

  task automatic test_lui();
    logic [31:0] v;
    run_instr(32'h1234_5137, 0, 4'd0, 1, 1);
    checks++; if (bus.alu_f !== m_f) begin errors++; $display("FAIL lui_f: got %h expected %h", bus.alu_f, m_f); end
    read_reg(2, v);
    checks++; if (v !== 32'h1234_5000) begin errors++; $display("FAIL lui_x2: got %h expected %h", v, 32'h1234_5000); end
  endtask

  task automatic test_sub_add();
    run_instr(enc_i(12'd7, 5'd0, 3'b000, 5'd1), 1, 4'd0, 1, 0);
    run_instr(enc_r(7'h20, 5'd1, 5'd1, 3'b000, 5'd3), 0, 4'd8, 1, 0);
    checks++; if (bus.alu_f !== 32'h0) begin errors++; $display("FAIL sub_f: got %h expected %h", bus.alu_f, 32'h0); end
    checks++; if ({bus.zf, bus.cf, bus.of} !== 3'b100) begin errors++; $display("FAIL sub_flags: got %b expected 100", {bus.zf, bus.cf, bus.of}); end
    run_instr({20'h80000, 5'd1, 7'h37}, 0, 4'd0, 1, 1);
    run_instr(enc_i(12'hFFF, 5'd1, 3'b000, 5'd1), 1, 4'd0, 1, 0);
    run_instr(enc_i(12'd1, 5'd0, 3'b000, 5'd2), 1, 4'd0, 1, 0);
    run_instr(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 0, 4'd0, 0, 0);
    checks++; if (bus.alu_f !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_f: got %h expected %h", bus.alu_f, 32'h8000_0000); end
    checks++; if ({bus.of, bus.cf, bus.sf, bus.zf} !== 4'b1010) begin errors++; $display("FAIL add_ovf_flags: got %b expected 1010", {bus.of, bus.cf, bus.sf, bus.zf}); end
  endtask

  task automatic test_x0_and_rbw();
    logic [31:0] v, old, k;
    run_instr(enc_i(12'd9, 5'd0, 3'b000, 5'd0), 1, 4'd0, 1, 0);
    read_reg(0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL x0_write: got %h expected %h", v, 32'h0); end
    old = $urandom_range(1, 1000);
    k = $urandom_range(1, 100);
    run_instr(enc_i(old[11:0], 5'd0, 3'b000, 5'd5), 1, 4'd0, 1, 0);
    run_instr(enc_i(k[11:0], 5'd5, 3'b000, 5'd5), 1, 4'd0, 1, 0);
    cycle(0, 0, 0, 1, 0, 4'd0);
    checks++; if (bus.alu_f !== old + k) begin errors++; $display("FAIL rbw_old_a: got %h expected %h", bus.alu_f, old + k); end
    cycle(0, 0, 0, 1, 0, 4'd0);
    checks++; if (bus.alu_f !== old + 2 * k) begin errors++; $display("FAIL rbw_new_a: got %h expected %h", bus.alu_f, old + 2 * k); end
  endtask

  task automatic test_shifts();
    run_instr(32'h8000_00B7, 0, 4'd0, 1, 1);
    run_instr(enc_i(12'h404, 5'd1, 3'b101, 5'd4), 1, 4'd13, 0, 0);
    checks++; if (bus.alu_f !== 32'hF800_0000) begin errors++; $display("FAIL srai: got %h expected %h", bus.alu_f, 32'hF800_0000); end
    run_instr(enc_i(12'h404, 5'd1, 3'b101, 5'd4), 1, 4'd5, 0, 0);
    checks++; if (bus.alu_f !== 32'h0800_0000) begin errors++; $display("FAIL srli: got %h expected %h", bus.alu_f, 32'h0800_0000); end
  endtask

  task automatic test_random_alu();
    logic [31:0] v;
    for (int n = 0; n < 60; n++) begin
      run_instr($urandom(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++; if (bus.alu_f !== m_f) begin errors++; $display("FAIL rand_f[%0d]: got %h expected %h", n, bus.alu_f, m_f); end
      checks++; if ({bus.zf, bus.sf, bus.cf, bus.of} !== {m_zf, m_sf, m_cf, m_of}) begin errors++; $display("FAIL rand_flags[%0d]: got %b expected %b", n, {bus.zf, bus.sf, bus.cf, bus.of}, {m_zf, m_sf, m_cf, m_of}); end
    end
    for (int i = 0; i < 32; i++) begin
      read_reg(i, v);
      checks++; if (v !== m_x[i]) begin errors++; $display("FAIL rand_x%0d: got %h expected %h", i, v, m_x[i]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 100; n++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      checks++; if ({bus.inst_addr, bus.alu_f, bus.opcode} !== {m_pc, m_f, m_ir[6:0]}) begin errors++; $display("FAIL b2b_state[%0d]: got %h/%h/%h expected %h/%h/%h", n, bus.inst_addr, bus.alu_f, bus.opcode, m_pc, m_f, m_ir[6:0]); end
      checks++; if ({bus.zf, bus.sf, bus.cf, bus.of} !== {m_zf, m_sf, m_cf, m_of}) begin errors++; $display("FAIL b2b_flags[%0d]: got %b expected %b", n, {bus.zf, bus.sf, bus.cf, bus.of}, {m_zf, m_sf, m_cf, m_of}); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ins, v;
    bus.PC_Write = 1; bus.IR_Write = 1; bus.Reg_Write = 1; bus.ALU_OP = 4'd0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.inst_addr !== 32'h0) begin errors++; $display("FAIL midrst_pc: got %h expected %h", bus.inst_addr, 32'h0); end
    checks++; if (bus.opcode !== 7'h0) begin errors++; $display("FAIL midrst_opcode: got %h expected %h", bus.opcode, 7'h0); end
    checks++; if ({bus.alu_f, bus.zf, bus.sf, bus.cf, bus.of} !== 36'h0) begin errors++; $display("FAIL midrst_f: got %h expected 0", {bus.alu_f, bus.zf, bus.sf, bus.cf, bus.of}); end
    model_reset();
    @(negedge clk);
    bus.PC_Write = 0; bus.IR_Write = 0; bus.Reg_Write = 0;
    rst_n = 1'b1;
    @(negedge clk);
    ins = $urandom();
    rom[0] = ins;
    cycle(1, 1, 0, 0, 0, 4'd0);
    checks++; if ({bus.funct7, bus.funct3, bus.opcode} !== {ins[31:25], ins[14:12], ins[6:0]}) begin errors++; $display("FAIL midrst_fetch: got %h expected %h", {bus.funct7, bus.funct3, bus.opcode}, {ins[31:25], ins[14:12], ins[6:0]}); end
    checks++; if (bus.inst_addr !== 32'd4) begin errors++; $display("FAIL midrst_pc4: got %h expected %h", bus.inst_addr, 32'd4); end
    for (int i = 1; i < 32; i++) begin
      read_reg(i, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL midrst_x%0d: got %h expected 0", i, v); end
    end
  endtask

  initial begin
`ifdef MC_DATAPATH_DEBUG_EN
    dbg_raddr = 5'd0;
    dbg_raddr2 = 5'd0;
`endif
    test_reset();
    test_pc_wrap();
    test_fetch();
    test_addi();
    test_lui();
    test_sub_add();
    test_x0_and_rbw();
    test_shifts();
    test_random_alu();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
